// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and fetch-stage types.
// Every fetch-related block imports these so opcode and width definitions exist in one place.
package cpu_isa_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_J     = 4'hF;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_ADDI  = 4'h9;
  localparam logic [3:0] OP_SW    = 4'h6;
  localparam logic [3:0] OP_RTYPE = 4'h0;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, IF/ID handshake towards decode and the execute redirect.
// Handshake: decode takes if_instr_o on a rising clk edge where if_valid_o=1 and if_ready_i=1.
interface instr_fetch_unit_if;
  import cpu_isa_pkg::*;

  logic [PC_W-1:0]    pc_o;
  logic [INSTR_W-1:0] instr_i;
  logic               if_valid_o;
  logic [INSTR_W-1:0] if_instr_o;
  logic [PC_W-1:0]    if_pc_o;
  logic               if_ready_i;
  logic               redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               halt_o;

  modport master (
    output pc_o,
    input  instr_i,
    output if_valid_o,
    output if_instr_o,
    output if_pc_o,
    input  if_ready_i,
    input  redirect_i,
    input  redirect_pc_i,
    output halt_o
  );

  modport slave (
    input  pc_o,
    output instr_i,
    input  if_valid_o,
    input  if_instr_o,
    input  if_pc_o,
    output if_ready_i,
    output redirect_i,
    output redirect_pc_i,
    input  halt_o
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC choice for the fetch stage: redirect, jump, increment or hold,
// plus detection of a jump whose target is its own address.
module fetch_next_pc
  import cpu_isa_pkg::*;
#(
  parameter logic [3:0] JUMP_OP = OP_J
) (
  input  fetch_state_t    i_state,
  input  logic            i_accept,
  input  logic [PC_W-1:0] i_pc,
  input  logic [3:0]      i_opcode,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_self_jump
);

  logic w_is_jump;

  always_comb begin
    w_is_jump   = (i_opcode == JUMP_OP);
    o_self_jump = w_is_jump && (i_target == i_pc);
    o_next_pc   = i_pc;
    // Redirect beats everything, even a stall or the halted state.
    if (i_redirect) begin
      o_next_pc = i_redirect_pc;
    end else if ((i_state == FETCH_RUN) && i_accept) begin
      if (o_self_jump) begin
        o_next_pc = i_pc;
      end else if (w_is_jump) begin
        o_next_pc = i_target;
      end else begin
        o_next_pc = i_pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the PC into a combinational ROM and registers the word
// into IF/ID, with predecoded jumps, branch redirect/flush, decode stall and self-jump halt.
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter logic [3:0]      JUMP_OP  = OP_J
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus,
  output fetch_state_t        o_dbg_state
);

  fetch_state_t       r_state,    w_state_next;
  logic [PC_W-1:0]    r_pc,       w_pc_next;
  logic               r_if_valid, w_if_valid_next;
  logic [INSTR_W-1:0] r_if_instr, w_if_instr_next;
  logic [PC_W-1:0]    r_if_pc,    w_if_pc_next;
  logic               r_halt,     w_halt_next;
  logic               w_accept;
  logic               w_self_jump;

  assign w_accept = !r_if_valid || bus.if_ready_i;

  fetch_next_pc #(
    .JUMP_OP (JUMP_OP)
  ) u_next_pc (
    .i_state       (r_state),
    .i_accept      (w_accept),
    .i_pc          (r_pc),
    .i_opcode      (bus.instr_i[15:12]),
    .i_target      (bus.instr_i[7:0]),
    .i_redirect    (bus.redirect_i),
    .i_redirect_pc (bus.redirect_pc_i),
    .o_next_pc     (w_pc_next),
    .o_self_jump   (w_self_jump)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH_RUN;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_if_valid <= w_if_valid_next;
      r_if_instr <= w_if_instr_next;
      r_if_pc    <= w_if_pc_next;
      r_halt     <= w_halt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_if_valid_next = r_if_valid;
    w_if_instr_next = r_if_instr;
    w_if_pc_next    = r_if_pc;
    w_halt_next     = r_halt;
    case (r_state)
      FETCH_RUN: begin
        // A flush only clears valid; the data fields keep their last loaded value.
        if (bus.redirect_i) begin
          w_if_valid_next = 1'b0;
        end else if (w_accept) begin
          w_if_instr_next = bus.instr_i;
          w_if_pc_next    = r_pc;
          w_if_valid_next = 1'b1;
          if (w_self_jump) begin
            w_state_next = FETCH_HALT;
            w_halt_next  = 1'b1;
          end
        end
      end
      FETCH_HALT: begin
        if (bus.redirect_i) begin
          w_if_valid_next = 1'b0;
          w_halt_next     = 1'b0;
          w_state_next    = FETCH_RUN;
        end else if (r_if_valid && bus.if_ready_i) begin
          w_if_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = FETCH_RUN;
      end
    endcase
  end

  assign bus.pc_o       = r_pc;
  assign bus.if_valid_o = r_if_valid;
  assign bus.if_instr_o = r_if_instr;
  assign bus.if_pc_o    = r_if_pc;
  assign bus.halt_o     = r_halt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed walk through jumps, stalls, redirects, halt and wrap,
// then randomized ROM/handshake traffic, all checked cycle by cycle against a fetch-stage model.
module tb_instr_fetch_unit;
  import cpu_isa_pkg::*;

  logic         clk;
  logic         reset;
  fetch_state_t dbg_state;
  logic [15:0]  rom [256];
  int           n_cmp;
  int           n_err;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (8'h00),
    .JUMP_OP  (4'hF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  assign bus.instr_i = rom[bus.pc_o];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [7:0]  m_ifpc;
  logic        m_halted;

  task automatic model_step(input bit rst, input bit rdy, input bit rdr, input logic [7:0] rpc);
    logic [15:0] w;
    if (rst) begin
      m_pc = 8'h00; m_valid = 0; m_instr = 16'h0; m_ifpc = 8'h00; m_halted = 0;
    end else if (m_halted) begin
      if (rdr) begin
        m_pc = rpc; m_valid = 0; m_halted = 0;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end else if (rdr) begin
      m_pc = rpc; m_valid = 0;
    end else if (!m_valid || rdy) begin
      w = rom[m_pc];
      m_instr = w; m_ifpc = m_pc; m_valid = 1;
      if (w[15:12] == 4'hF) begin
        if (w[7:0] == m_pc) m_halted = 1;
        else m_pc = w[7:0];
      end else begin
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", 32'(bus.pc_o), 32'(m_pc));
    check("valid", 32'(bus.if_valid_o), 32'(m_valid));
    check("if_instr", 32'(bus.if_instr_o), 32'(m_instr));
    check("if_pc", 32'(bus.if_pc_o), 32'(m_ifpc));
    check("halt", 32'(bus.halt_o), 32'(m_halted));
    check("state", 32'(dbg_state == FETCH_HALT), 32'(m_halted));
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input bit rst, input bit rdy, input bit rdr, input logic [7:0] rpc);
    reset             = rst;
    bus.if_ready_i    = rdy;
    bus.redirect_i    = rdr;
    bus.redirect_pc_i = rpc;
    model_step(rst, rdy, rdr, rpc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 1, 0, 8'h00);
  endtask

  initial begin
    logic [3:0] op;
    n_cmp = 0;
    n_err = 0;
    reset = 1;
    bus.if_ready_i = 0;
    bus.redirect_i = 0;
    bus.redirect_pc_i = 0;
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom_range(0, 16'h7FFF));
    rom[0]  = 16'h9011;
    rom[1]  = 16'h9021;
    rom[2]  = 16'h9035;
    rom[3]  = 16'h9051;
    rom[9]  = 16'hF004;
    rom[12] = 16'hF00C;

    // reset and sequential fetch
    do_cycle(1, 1, 0, 8'h00);
    check("rst_pc", 32'(bus.pc_o), 32'h00);
    check("rst_valid", 32'(bus.if_valid_o), 32'h0);
    check("rst_instr", 32'(bus.if_instr_o), 32'h0);
    do_cycle(0, 1, 0, 8'h00);
    check("first_word", 32'(bus.if_instr_o), 32'h9011);
    check("first_valid", 32'(bus.if_valid_o), 32'h1);
    run(3);
    check("addi4", 32'(bus.if_instr_o), 32'h9051);
    check("pc4", 32'(bus.pc_o), 32'h04);

    // jump at 9 back to 4 with no bubble
    run(6);
    check("jump_pc", 32'(bus.pc_o), 32'h04);
    check("jump_word", 32'(bus.if_instr_o), 32'hF004);
    check("jump_ifpc", 32'(bus.if_pc_o), 32'h09);
    run(1);
    check("after_jump_ifpc", 32'(bus.if_pc_o), 32'h04);

    // 3-cycle decode stall at pc 5
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 0, 8'h00);
      check("stall_pc", 32'(bus.pc_o), 32'h05);
    end
    run(1);
    check("resume_ifpc", 32'(bus.if_pc_o), 32'h05);

    // redirect while stalled at pc 6
    do_cycle(0, 0, 0, 8'h00);
    do_cycle(0, 0, 1, 8'h0A);
    check("redir_pc", 32'(bus.pc_o), 32'h0A);
    check("redir_valid", 32'(bus.if_valid_o), 32'h0);
    run(1);
    check("redir_ifpc", 32'(bus.if_pc_o), 32'h0A);

    // self-jump at 0x0C halts; drain; redirect out
    run(2);
    check("halt_set", 32'(bus.halt_o), 32'h1);
    check("halt_word", 32'(bus.if_instr_o), 32'hF00C);
    do_cycle(0, 0, 0, 8'h00);
    do_cycle(0, 0, 0, 8'h00);
    check("halt_hold_valid", 32'(bus.if_valid_o), 32'h1);
    run(3);
    check("halt_drained", 32'(bus.if_valid_o), 32'h0);
    check("halt_pc", 32'(bus.pc_o), 32'h0C);
    do_cycle(0, 1, 1, 8'h00);
    check("unhalt", 32'(bus.halt_o), 32'h0);
    run(1);
    check("restart_ifpc", 32'(bus.if_pc_o), 32'h00);

    // PC wrap
    rom[8'hFE] = 16'h9001;
    rom[8'hFF] = 16'h9002;
    do_cycle(0, 1, 1, 8'hFE);
    run(2);
    check("wrap_pc", 32'(bus.pc_o), 32'h00);
    check("wrap_ifpc", 32'(bus.if_pc_o), 32'hFF);

    // reset beats stall + redirect
    do_cycle(0, 0, 0, 8'h00);
    do_cycle(1, 0, 1, 8'h33);
    check("rst_mid_pc", 32'(bus.pc_o), 32'h00);
    check("rst_mid_valid", 32'(bus.if_valid_o), 32'h0);

    // randomized program and handshake traffic
    for (int a = 0; a < 256; a++) begin
      op = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rom[a] = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      if (op == 4'hF && $urandom_range(0, 3) == 0) rom[a][7:0] = 8'(a);
    end
    for (int c = 0; c < 1500; c++) begin
      do_cycle($urandom_range(0, 149) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0,
               8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage that drives the 8-bit program counter into the combinational instruction ROM and captures the returned 16-bit word into an IF/ID register for decode.
- Owns PC sequencing: sequential increment, zero-bubble predecoded jumps, execute-stage branch redirect with flush, decode back-pressure, and halt on a self-jump.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- JUMP_OP, 4'hF, opcode (instr[15:12]) of the absolute jump `j addr`; the target is instr[7:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_o  output  8  current fetch address, driven to the ROM address input.
- instr_i  input  16  ROM read data for pc_o, valid in the same cycle (combinational ROM).
- if_valid_o  output  1  IF/ID register holds a valid instruction.
- if_instr_o  output  16  IF/ID instruction.
- if_pc_o  output  8  address of if_instr_o.
- if_ready_i  input  1  decode accepts if_instr_o this cycle when if_valid_o=1.
- redirect_i  input  1  taken branch from execute; flush and refetch.
- redirect_pc_i  input  8  branch target.
- halt_o  output  1  fetch halted.

Behaviour:
- Reset, synchronous and active-high: pc_o=RESET_PC, if_valid_o=0, if_instr_o=16'h0000, if_pc_o=8'h00, halt_o=0, state=RUN. Reset has priority over every other input. A reset in mid-operation discards all fetch state.
- Define `accept = !if_valid_o || if_ready_i`. The IF/ID register may load only when accept=1.
- RUN state, evaluated in priority order on each clk edge:
  1. redirect_i=1: pc_o<=redirect_pc_i; if_valid_o<=0. The in-flight word is flushed and instr_i is ignored. This applies even when decode is stalled.
  2. accept=0 (stall): hold pc_o, if_instr_o, if_pc_o and if_valid_o unchanged.
  3. accept=1: if_instr_o<=instr_i; if_pc_o<=pc_o; if_valid_o<=1. The next PC is computed as follows:
     - If instr_i[15:12]==JUMP_OP and instr_i[7:0]==pc_o (self-jump): pc_o holds and state<=HALT.
     - Else if instr_i[15:12]==JUMP_OP: pc_o<=instr_i[7:0]. This is a zero-bubble jump; the jump word itself is still passed to decode.
     - Else: pc_o<=pc_o+1, modulo 256 (8'hFF wraps to 8'h00).
- HALT state:
  - halt_o=1 (registered; it is set on the edge that enters HALT). pc_o is frozen and no new word is loaded.
  - The IF/ID register still drains: when if_valid_o=1 and if_ready_i=1, then if_valid_o<=0.
  - redirect_i=1 causes pc_o<=redirect_pc_i, if_valid_o<=0, halt_o<=0, state<=RUN.
- Latency: a word is presented on if_instr_o one cycle after pc_o addresses it. With no stalls, throughput is one instruction per cycle.
- Simultaneous events:
  - redirect_i together with a jump in instr_i: redirect wins.
  - redirect_i together with a stall: redirect wins and the held word is dropped.
  - redirect_i asserted while already in HALT: handled as described under HALT state.
- if_pc_o and if_instr_o change only on a load or on reset. A flush clears if_valid_o only; the data fields are left unchanged.

Decomposition:
- Shared package `cpu_isa_pkg` holds:
  - opcode constants: OP_J=4'hF, OP_BEQ=4'h7, OP_ADDI=4'h9, OP_SW=4'h6, OP_RTYPE=4'h0;
  - PC_W=8 and INSTR_W=16;
  - state enum {FETCH_RUN, FETCH_HALT}.
- One natural sub-module, `fetch_next_pc`: combinational next-PC selection (redirect / jump / increment / hold) plus self-jump detection. The PC register, IF/ID register and FSM stay in the parent.

Test Plan:
- Reset, then run with if_ready_i=1 and the ROM loaded with 4x addi (16'h9011, 16'h9021, 16'h9035, 16'h9051) -> pc_o steps 0,1,2,3,4; if_pc_o/if_instr_o give 0/9011, 1/9021, ... one cycle later; if_valid_o rises one cycle after reset release.
- ROM[9]=16'hF004 -> cycle after pc_o=9: pc_o=4 and if_instr_o=F004 with if_pc_o=9; no bubble, so the next if_pc_o is 4.
- With if_valid_o=1, hold if_ready_i=0 for 3 cycles -> pc_o, if_instr_o and if_pc_o are stable for all 3; the fetch sequence resumes without loss once ready returns.
- redirect_i=1 with redirect_pc_i=8'h0A while stalled at pc_o=6 -> next cycle pc_o=0A and if_valid_o=0; the cycle after, if_pc_o=0A.
- ROM[12]=16'hF00C (self-jump) -> F00C is delivered with if_pc_o=0C; halt_o=1; pc_o stays 0C indefinitely; if_valid_o drops after decode accepts; redirect to 8'h00 -> halt_o=0 and fetch restarts at 0.
- pc_o=8'hFF with a non-jump word -> next pc_o=8'h00; assert reset during a stall with a pending redirect -> pc_o=RESET_PC and if_valid_o=0 next cycle.
